// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - round-robin arbiter sharing one line-wide memory port between icache and dcache
// Grant is held from strobe until pmem_resp, followed by one RELEASE recovery cycle.
module pmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic              busy,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {IDLE, SERVE, RELEASE} state_t;

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;
  logic [1:0]        grant_q, grant_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;

  logic i_req, d_req, pick_d;

  assign i_req  = i_read;
  assign d_req  = d_read | d_write;
  // dcache wins when alone, or on a tie when icache owned the port last
  assign pick_d = d_req & (~i_req | ~last_d_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_d_q       <= 1'b1;
      grant_q        <= 2'b00;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      last_d_q       <= last_d_d;
      grant_q        <= grant_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_d_d       = last_d_q;
    grant_d        = grant_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    case (state_q)
      IDLE: begin
        if (i_req | d_req) begin
          state_d = SERVE;
          if (pick_d) begin
            grant_d        = 2'b10;
            pmem_read_d    = ~d_write;
            pmem_write_d   = d_write;
            pmem_address_d = d_address;
            pmem_wdata_d   = d_wdata;
          end else begin
            grant_d        = 2'b01;
            pmem_read_d    = 1'b1;
            pmem_write_d   = 1'b0;
            pmem_address_d = i_address;
            pmem_wdata_d   = '0;
          end
        end
      end
      SERVE: begin
        if (pmem_resp) begin
          state_d      = RELEASE;
          last_d_d     = grant_q[1];
          grant_d      = 2'b00;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign i_resp       = (state_q == SERVE) & pmem_resp & grant_q[0];
  assign d_resp       = (state_q == SERVE) & pmem_resp & grant_q[1];
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign busy         = (state_q != IDLE);
  assign grant        = grant_q;

endmodule
